ntt_mlkem_masked_bfu_addsub: RTL
================================

Name: ntt_mlkem_masked_bfu_addsub

Overview:
- Downstream neighbour of the masked BFU multiplier in the masked ML-KEM NTT butterfly.
- Delay-aligns the butterfly's u operand (two arithmetic shares) with the multiplier's 8-clk output m = w*v.
- Performs share-wise modular add and subtract mod q = 3329 to form the Cooley-Tukey outputs u+m and u-m, and registers the result.
- Shares are never recombined; every operation is share-local.

Parameters:
- WIDTH, 24, share width; values carried in bits [11:0], upper bits zero.
- MULT_LAT, 8, multiplier latency in clks; sets the depth of the u/valid delay line.
- MLKEM_Q, 3329, modulus.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- zeroize  in  1  synchronous clear of all state.
- valid_in  in  1  u_in is presented in the same cycle its v/w pair enters the multiplier.
- u_in  in  [1:0][WIDTH-1:0]  u arithmetic shares, each in [0,q).
- mult_res  in  [1:0][WIDTH-1:0]  multiplier output shares, each in [0,q), valid MULT_LAT clks after valid_in.
- rnd  in  [11:0]  fresh randomness; used only with the optional feature.
- add_out  out  [1:0][WIDTH-1:0]  shares of (u+m) mod q.
- sub_out  out  [1:0][WIDTH-1:0]  shares of (u-m) mod q.
- valid_out  out  1  add_out/sub_out valid.

Behaviour:
- Reset: reset_n low asynchronously clears the delay line, valid pipe, add_out, sub_out and valid_out to 0.
- Zeroize: when high at a clk edge, clears the same state to 0. It has priority over capture.
- Delay line: MULT_LAT-stage shift register holding {valid, u shares}. It advances every clk with no stall. The valid bit is stored, so bubbles propagate intact.
- Alignment: at stage MULT_LAT, u_d meets mult_res.
- Combine, share-local, for i in {0,1}:
  - s = u_d[i] + m[i], 13 bits; add[i] = (s >= q) ? s-q : s.
  - d = u_d[i] + q - m[i], 13 bits; sub[i] = (d >= q) ? d-q : d.
- Output register: add[i], sub[i] and the delayed valid are registered once.
- Latency: valid_out rises exactly MULT_LAT+1 = 9 clks after valid_in; throughput is 1 per clk.
- Output hold: add_out/sub_out update only when the delayed valid is 1; otherwise they hold their last value. valid_out follows the delayed valid every cycle.
- Width: outputs are zero-extended to WIDTH; bits [WIDTH-1:12] are always 0.
- Boundaries:
  - Share = q-1 with partner q-1 gives add = q-2.
  - u = m gives sub share 0.
  - Inputs >= q are illegal; flag them with a simulation assertion, not RTL logic.
- Reset or zeroize mid-stream flushes all in-flight samples; no valid_out results from pre-reset inputs.
- Back-to-back valid_in for N clks gives back-to-back valid_out for N clks.

Optional Feature:
- Macro: MLKEM_MASKED_BFU_REFRESH_EN.
- Defined: before the output register, both add and sub shares are refreshed:
  - share0 += r mod q; share1 -= r mod q.
  - r = rnd mod q via a single conditional subtract on the 12-bit value.
  - Adds no latency; unmasked values are unchanged.
- Undefined: rnd is unused and outputs are the plain share-wise results.

Decomposition:
- Shared package ntt_defines_pkg gains MLKEM_Q, MLKEM_MASKED_MULT_LAT = 8, and a typedef for a two-share coefficient.
- One sub-module, ntt_mlkem_mod_addsub: combinational share-level a+b mod q and a-b mod q. Instantiated once per share, two in total.

Test Plan:
- Single sample: u shares (1000,200), m shares (3000,100), i.e. u=1200, m=3100.
  - add shares (671,300), sum 971 = (1200+3100) mod 3329.
  - sub shares (1329,100), sum 1429 = (1200-3100) mod 3329.
  - valid_out at exactly clk 9.
- Wrap extremes: u=(3328,3328), m=(3328,3328) -> add=(3327,3327), sub=(0,0).
- Streaming with bubbles: random pattern valid_in=1101_0011 over 200 random in-range samples.
  - valid_out is the same pattern delayed 9 clks.
  - Unmasked sums match a reference model mod q.
- reset_n pulsed low at clk 4 of an 8-sample burst -> outputs 0 immediately; valid_out never rises for the burst.
- zeroize at clk 5 of a burst -> same flush.
  - New valid_in at clk 6 produces valid_out at clk 15.
- With MLKEM_MASKED_BFU_REFRESH_EN, rnd=3400 (r=71), u=(10,0), m=(5,0):
  - add=(86,3258), sub=(76,3258).
  - Unmasked 15 and 5 preserved.

Source files
------------

// File: rtl/ntt_defines_pkg.sv
// ntt_defines_pkg
// Shared constants and helpers for the ML-KEM NTT datapath.
//   MLKEM_Q               : ML-KEM modulus (3329)
//   MLKEM_MASKED_MULT_LAT : latency of the masked BFU multiplier, in clocks
//   COEF_W                : bits needed to carry one coefficient share in [0,q)
//   coef_t / coef2_t      : one share, and a two-share arithmetic masking
//   mod_add_q / mod_sub_q : share-local modular add/subtract, operands in [0,q)
package ntt_defines_pkg;

  localparam int MLKEM_Q               = 3329;
  localparam int MLKEM_MASKED_MULT_LAT = 8;
  localparam int COEF_W                = 12;

  typedef logic [COEF_W-1:0]      coef_t;
  typedef logic [1:0][COEF_W-1:0] coef2_t;

  // a + b mod q. The sum of two values in [0,q) is below 2q, so a single
  // conditional subtract is enough; one extra bit holds the carry.
  function automatic coef_t mod_add_q(input coef_t a, input coef_t b,
                                      input logic [COEF_W:0] q);
    logic [COEF_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= q) begin
      s = s - q;
    end
    return s[COEF_W-1:0];
  endfunction

  // a - b mod q, computed as a + q - b so the intermediate never goes
  // negative; the result lies in [1, 2q) and needs one conditional subtract.
  function automatic coef_t mod_sub_q(input coef_t a, input coef_t b,
                                      input logic [COEF_W:0] q);
    logic [COEF_W:0] d;
    d = {1'b0, a} + q - {1'b0, b};
    if (d >= q) begin
      d = d - q;
    end
    return d[COEF_W-1:0];
  endfunction

endpackage

// File: rtl/ntt_mlkem_mod_addsub.sv
// ntt_mlkem_mod_addsub
// Combinational share-level modular add and subtract. One instance handles
// a single arithmetic share; it never sees the partner share, so no
// recombination of the masked value can happen here.
// Ports:
//   a    : share of u, in [0,q)
//   b    : share of m, in [0,q)
//   sum  : (a + b) mod q
//   diff : (a - b) mod q
module ntt_mlkem_mod_addsub #(
  parameter int MLKEM_Q = ntt_defines_pkg::MLKEM_Q
) (
  input  ntt_defines_pkg::coef_t a,
  input  ntt_defines_pkg::coef_t b,
  output ntt_defines_pkg::coef_t sum,
  output ntt_defines_pkg::coef_t diff
);
  import ntt_defines_pkg::*;

  localparam logic [COEF_W:0] Q13 = (COEF_W+1)'(MLKEM_Q);

  assign sum  = mod_add_q(a, b, Q13);
  assign diff = mod_sub_q(a, b, Q13);

endmodule

// File: rtl/ntt_mlkem_masked_bfu_addsub.sv
// ntt_mlkem_masked_bfu_addsub
// Add/subtract back end of the masked ML-KEM Cooley-Tukey butterfly. The u
// operand (two arithmetic shares) is delayed MULT_LAT clocks so that it meets
// the multiplier result m = w*v, then u+m and u-m are formed share by share
// mod q and registered. Total latency valid_in -> valid_out is MULT_LAT+1.
//
// Ports:
//   clk       : clock
//   reset_n   : asynchronous active-low reset, clears all state
//   zeroize   : synchronous clear of all state, wins over capture
//   valid_in  : u_in valid (same cycle its v/w pair enters the multiplier)
//   u_in      : u shares, each in [0,q), upper bits zero
//   mult_res  : multiplier output shares, valid MULT_LAT clocks after valid_in
//   rnd       : fresh randomness for the output share refresh
//   add_out   : shares of (u+m) mod q
//   sub_out   : shares of (u-m) mod q
//   valid_out : add_out/sub_out carry a new result this cycle
//
// Optional feature macro MLKEM_MASKED_BFU_REFRESH_EN: when defined, both
// outputs are re-masked with r = rnd mod q (share0 += r, share1 -= r) before
// the output register. Without it rnd is ignored.
module ntt_mlkem_masked_bfu_addsub #(
  parameter int WIDTH    = 24,
  parameter int MULT_LAT = ntt_defines_pkg::MLKEM_MASKED_MULT_LAT,
  parameter int MLKEM_Q  = ntt_defines_pkg::MLKEM_Q
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  zeroize,
  input  logic                  valid_in,
  input  logic [1:0][WIDTH-1:0] u_in,
  input  logic [1:0][WIDTH-1:0] mult_res,
  input  logic [11:0]           rnd,
  output logic [1:0][WIDTH-1:0] add_out,
  output logic [1:0][WIDTH-1:0] sub_out,
  output logic                  valid_out
);
  import ntt_defines_pkg::*;

  localparam logic [COEF_W:0] Q13 = (COEF_W+1)'(MLKEM_Q);

  coef2_t              u_now;
  coef2_t              m_now;
  coef2_t              u_pipe [MULT_LAT];
  logic [MULT_LAT-1:0] vld_pipe;
  coef2_t              add_res;
  coef2_t              sub_res;
  coef2_t              add_fin;
  coef2_t              sub_fin;
  coef2_t              add_q;
  coef2_t              sub_q;
  logic                vld_d;

  // Legal shares never exceed 12 bits, so only the low bits are carried.
  assign u_now[0] = u_in[0][COEF_W-1:0];
  assign u_now[1] = u_in[1][COEF_W-1:0];
  assign m_now[0] = mult_res[0][COEF_W-1:0];
  assign m_now[1] = mult_res[1][COEF_W-1:0];

  logic unused_hi;
  assign unused_hi = ^{u_in[0][WIDTH-1:COEF_W], u_in[1][WIDTH-1:COEF_W],
                       mult_res[0][WIDTH-1:COEF_W], mult_res[1][WIDTH-1:COEF_W]};

  // Delay line for {valid, u}. It never stalls; storing the valid bit next
  // to the data keeps bubbles aligned with the samples around them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      for (int k = 0; k < MULT_LAT; k++) begin
        u_pipe[k] <= '0;
      end
    end else if (zeroize) begin
      vld_pipe <= '0;
      for (int k = 0; k < MULT_LAT; k++) begin
        u_pipe[k] <= '0;
      end
    end else begin
      vld_pipe[0] <= valid_in;
      u_pipe[0]   <= u_now;
      for (int k = 1; k < MULT_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        u_pipe[k]   <= u_pipe[k-1];
      end
    end
  end

  assign vld_d = vld_pipe[MULT_LAT-1];

  // One add/sub unit per share keeps the two shares on separate logic.
  for (genvar i = 0; i < 2; i++) begin : g_share
    ntt_mlkem_mod_addsub #(
      .MLKEM_Q (MLKEM_Q)
    ) u_addsub (
      .a    (u_pipe[MULT_LAT-1][i]),
      .b    (m_now[i]),
      .sum  (add_res[i]),
      .diff (sub_res[i])
    );
  end

`ifdef MLKEM_MASKED_BFU_REFRESH_EN
  localparam coef_t Q12 = COEF_W'(MLKEM_Q);

  // rnd is below 4096 < 2q, so a single conditional subtract reduces it.
  // Adding r to one share and removing it from the other leaves the
  // unmasked value untouched while drawing a fresh masking.
  coef_t r_mod;
  assign r_mod = (rnd >= Q12) ? (rnd - Q12) : rnd;

  assign add_fin[0] = mod_add_q(add_res[0], r_mod, Q13);
  assign add_fin[1] = mod_sub_q(add_res[1], r_mod, Q13);
  assign sub_fin[0] = mod_add_q(sub_res[0], r_mod, Q13);
  assign sub_fin[1] = mod_sub_q(sub_res[1], r_mod, Q13);
`else
  logic unused_rnd;
  assign unused_rnd = ^rnd;

  assign add_fin = add_res;
  assign sub_fin = sub_res;
`endif

  // Results load only on a valid delayed sample and otherwise hold, so a
  // bubble never overwrites the last good butterfly output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      add_q     <= '0;
      sub_q     <= '0;
      valid_out <= 1'b0;
    end else if (zeroize) begin
      add_q     <= '0;
      sub_q     <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= vld_d;
      if (vld_d) begin
        add_q <= add_fin;
        sub_q <= sub_fin;
      end
    end
  end

  assign add_out[0] = WIDTH'(add_q[0]);
  assign add_out[1] = WIDTH'(add_q[1]);
  assign sub_out[0] = WIDTH'(sub_q[0]);
  assign sub_out[1] = WIDTH'(sub_q[1]);

  // Out-of-range shares break the single-subtract reduction; they are a
  // caller error and are only flagged in simulation.
  a_u_in_range : assert property (@(posedge clk) disable iff (!reset_n)
    valid_in |-> (u_in[0] < WIDTH'(MLKEM_Q)) && (u_in[1] < WIDTH'(MLKEM_Q)));

  a_mult_res_range : assert property (@(posedge clk) disable iff (!reset_n)
    vld_d |-> (mult_res[0] < WIDTH'(MLKEM_Q)) && (mult_res[1] < WIDTH'(MLKEM_Q)));

endmodule
